qc_ldpc_parity_serializer: RTL
==============================

# qc_ldpc_parity_serializer

Downstream stage of the QC-LDPC encoder data path. Once the 16 parallel 88-bit SRAA accumulators have finished a codeword, it captures the complete 1408-bit parity vector (`generated_vector`) in one cycle. It then streams the vector out one bit per accepted transfer over a valid/ready handshake, reporting circulant-block and bit position so the channel interface can frame the output. This frees the SRAA bank to clear and start the next information block while the previous parity is still draining.

## Interface
Parameters:
- `CIRCULANT_SIZE`, default 88: bits per circulant block.
- `NUM_BLOCKS`, default 16: circulant blocks per parity vector.
- `VEC_W`, default `NUM_BLOCKS*CIRCULANT_SIZE` (1408): parity vector width. Derived; do not override.

Ports:
- `clk`, in, 1: single clock; every register updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `generated_vector`, in, `VEC_W`: parity vector from the encoder data path.
- `parity_valid`, in, 1: vector is stable. Level signal, held by the controller until accepted.
- `parity_ready`, out, 1: block can capture a vector.
- `flush`, in, 1: synchronous abort of the current stream.
- `code_bit`, out, 1: current serial parity bit.
- `code_valid`, out, 1: `code_bit` is valid.
- `code_ready`, in, 1: consumer accepts `code_bit` this cycle.
- `block_index`, out, 4: circulant block of `code_bit`, 0..`NUM_BLOCKS`-1.
- `bit_index`, out, 7: bit within block, 0..`CIRCULANT_SIZE`-1.
- `code_last`, out, 1: `code_bit` is the final bit of the vector.
- `frame_done`, out, 1: one-cycle pulse after the last bit is transferred.

## Operation
- Two states, `IDLE` and `SHIFT`. State register, shift register (`VEC_W`), 4-bit block counter and 7-bit bit counter are all registered.
- Outputs are decoded from registered state only, with no combinational input→output paths:
  - `parity_ready` = (state==`IDLE`)
  - `code_valid` = (state==`SHIFT`)
  - `code_bit` = shift_reg[`VEC_W`-1]
  - `block_index` / `bit_index` = the counters
  - `code_last` = `code_valid` and block==`NUM_BLOCKS`-1 and bit==`CIRCULANT_SIZE`-1
- Load, in `IDLE` when `parity_valid`=1:
  - shift_reg <= `generated_vector`
  - both counters <= 0
  - state <= `SHIFT`
- Transfer, in `SHIFT` when `code_ready`=1:
  - shift_reg shifts left by one and zero-fills the LSB.
  - bit counter increments. At `CIRCULANT_SIZE`-1 it wraps to 0 and the block counter increments.
- Output order is MSB first: `generated_vector`[1407] (block 0, bit 0) through [0] (block 15, bit 87). Block k covers vector bits [`VEC_W`-1-k*88 -: 88], which is SRAA instance k+1 counted from the top.
- Last transfer (`code_last` and `code_ready`):
  - state <= `IDLE`, counters <= 0.
  - `frame_done` pulses high in the next cycle, the same cycle `parity_ready` returns high.
- Stall: with `code_ready`=0 and `code_valid`=1, `code_bit`, the indices and `code_last` hold unchanged.
- Counters never exceed their terminal values. Indices read 0 in `IDLE`.

## Timing
- Reset (`reset`=1 at an edge) forces:
  - state `IDLE`, shift_reg 0, counters 0
  - `parity_ready`=1
  - `code_valid`=0, `code_bit`=0, `code_last`=0, `frame_done`=0
- Reset overrides every other input, including mid-stream. A partial frame is discarded without a `frame_done` pulse.
- `flush`=1 in any state returns to `IDLE` with shift_reg and counters cleared and no `frame_done`. `reset` has priority over `flush`.
- `flush` together with `parity_valid` in `IDLE`: the flush wins and the vector is not captured.
- Load latency: `parity_valid` sampled high at edge N means `code_valid`=1 and `code_bit`=vector[1407] from edge N.
- Throughput: one bit per cycle with `code_ready` held high. A full frame takes 1408 cycles in `SHIFT` plus 1 cycle in `IDLE` before the next load, i.e. 1409 cycles per vector.
- `parity_valid` while in `SHIFT` is ignored. The controller holds it until `parity_ready`, and the vector must remain stable until then.
- `generated_vector` is sampled only on the load edge. Later changes do not affect the frame.

## Test plan
- Reset, then idle: `parity_ready`=1, `code_valid`=0, `code_bit`=0, and no `frame_done` for 20 cycles.
- Load a vector with only bit 1407 and bit 0 set, `code_ready`=1: first bit is 1 at block 0/bit 0; bits 2..1407 are 0; 1408th bit is 1 with `code_last`=1 at block 15/bit 87; `frame_done` one cycle later.
- Load 0xAAAA… pattern with `code_ready` toggled pseudo-randomly: the captured stream equals the vector MSB first, and the outputs hold stable during every stall cycle.
- Boundary wrap: at bit 87 of block 3, the next accepted transfer reads block 4/bit 0.
- `flush` asserted at transfer 500: next cycle is `IDLE`, `parity_ready`=1, and there is no `frame_done`. An immediate new load restarts at block 0/bit 0.
- `reset` asserted mid-frame together with `parity_valid`=1: the block returns to the reset values. The vector is captured on the first edge after `reset` drops, and `code_valid` rises that cycle.

Source files
------------

// File: rtl/qc_ldpc_parity_serializer.sv
// Captures the full QC-LDPC parity vector in one cycle and streams it out MSB first,
// one bit per valid/ready transfer, tagged with circulant block and bit position.
module qc_ldpc_parity_serializer #(
  parameter int CIRCULANT_SIZE = 88,
  parameter int NUM_BLOCKS     = 16,
  parameter int VEC_W          = NUM_BLOCKS * CIRCULANT_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VEC_W-1:0] generated_vector,
  input  logic             parity_valid,
  output logic             parity_ready,
  input  logic             flush,
  output logic             code_bit,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [3:0]       block_index,
  output logic [6:0]       bit_index,
  output logic             code_last,
  output logic             frame_done
);

  // state | meaning
  // IDLE  | empty, waiting for parity_valid to capture a vector
  // SHIFT | presenting shift_reg MSB, advancing on each accepted transfer
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [3:0] BLK_LAST = 4'(NUM_BLOCKS - 1);
  localparam logic [6:0] BIT_LAST = 7'(CIRCULANT_SIZE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_shift;
  logic [3:0]       r_blk;
  logic [6:0]       r_bit;
  logic             r_frame_done;
  logic             w_load;
  logic             w_xfer;
  logic             w_last;

  assign w_last = (r_state == SHIFT) && (r_blk == BLK_LAST) && (r_bit == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush && parity_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (code_ready) begin
          w_xfer = 1'b1;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flush clears the datapath the same way reset does, so an aborted frame never pulses frame_done.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_shift      <= '0;
      r_blk        <= '0;
      r_bit        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_xfer && w_last;
      if (w_load) begin
        r_shift <= generated_vector;
        r_blk   <= '0;
        r_bit   <= '0;
      end else if (w_xfer) begin
        r_shift <= {r_shift[VEC_W-2:0], 1'b0};
        if (w_last) begin
          r_blk <= '0;
          r_bit <= '0;
        end else if (r_bit == BIT_LAST) begin
          r_blk <= r_blk + 4'd1;
          r_bit <= '0;
        end else begin
          r_bit <= r_bit + 7'd1;
        end
      end
    end
  end

  assign parity_ready = (r_state == IDLE);
  assign code_valid   = (r_state == SHIFT);
  assign code_bit     = r_shift[VEC_W-1];
  assign block_index  = r_blk;
  assign bit_index    = r_bit;
  assign code_last    = w_last;
  assign frame_done   = r_frame_done;

endmodule
